// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester, response and ALU-side signals for the shared-ALU arbiter.
// The master side is the environment (requesters, consumer, ALU). The slave side is the arbiter.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 64,
  parameter int CTL_W = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [CTL_W-1:0] req0_ctl;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [CTL_W-1:0] req1_ctl;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH-1:0] resp_result;
  logic             resp_zero;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [CTL_W-1:0] alu_ctl;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctl,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_ctl,
    input  req1_ready,
    input  resp_valid, resp_id, resp_result, resp_zero,
    output resp_ready,
    input  alu_a, alu_b, alu_ctl,
    output alu_result, alu_zero
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctl,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_ctl,
    output req1_ready,
    output resp_valid, resp_id, resp_result, resp_zero,
    input  resp_ready,
    output alu_a, alu_b, alu_ctl,
    input  alu_result, alu_zero
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters.
// Each operation takes one EXEC cycle, then its result is held in RESP until it is consumed.
module alu_share_arbiter #(
  parameter int WIDTH = 64,
  parameter int CTL_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  alu_share_arbiter_if.slave bus,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a   [2];
  logic [WIDTH-1:0] req_b   [2];
  logic [CTL_W-1:0] req_ctl [2];

  logic             any_req;
  logic             grant_id;
  logic             accept;

  logic             last_id_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CTL_W-1:0] ctl_reg;

  logic             resp_valid_reg;
  logic             resp_id_reg;
  logic [WIDTH-1:0] resp_result_reg;
  logic             resp_zero_reg;

  assign req_valid  = {bus.req1_valid, bus.req0_valid};
  assign req_a[0]   = bus.req0_a;
  assign req_a[1]   = bus.req1_a;
  assign req_b[0]   = bus.req0_b;
  assign req_b[1]   = bus.req1_b;
  assign req_ctl[0] = bus.req0_ctl;
  assign req_ctl[1] = bus.req1_ctl;

  assign any_req = |req_valid;

  // With both requesting, the port that did not win last time takes the grant.
  assign grant_id = (req_valid == 2'b11) ? ~last_id_reg : req_valid[1];

  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign req_ready[gi] = accept && (grant_id == 1'(gi));
  end

  assign bus.req0_ready = req_ready[0];
  assign bus.req1_ready = req_ready[1];

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = RESP;
      end
      RESP: begin
        // Taking the held result frees the slot, so a waiting request is accepted in the same cycle.
        if (bus.resp_ready) begin
          if (any_req) begin
            accept     = 1'b1;
            state_next = EXEC;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // last_id_reg doubles as the owner of the operation that is in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_id_reg <= 1'b1;
      a_reg       <= '0;
      b_reg       <= '0;
      ctl_reg     <= '0;
    end else if (accept) begin
      last_id_reg <= grant_id;
      a_reg       <= req_a[grant_id];
      b_reg       <= req_b[grant_id];
      ctl_reg     <= req_ctl[grant_id];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid_reg  <= 1'b0;
      resp_id_reg     <= 1'b0;
      resp_result_reg <= '0;
      resp_zero_reg   <= 1'b0;
    end else if (state_reg == EXEC) begin
      resp_valid_reg  <= 1'b1;
      resp_id_reg     <= last_id_reg;
      resp_result_reg <= bus.alu_result;
      resp_zero_reg   <= bus.alu_zero;
    end else if ((state_reg == RESP) && bus.resp_ready) begin
      resp_valid_reg  <= 1'b0;
    end
  end

  assign bus.alu_a       = a_reg;
  assign bus.alu_b       = b_reg;
  assign bus.alu_ctl     = ctl_reg;

  assign bus.resp_valid  = resp_valid_reg;
  assign bus.resp_id     = resp_id_reg;
  assign bus.resp_result = resp_result_reg;
  assign bus.resp_zero   = resp_zero_reg;

  assign busy = (state_reg != IDLE);

endmodule
